// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared game-logic definitions: the frame scheduler state encoding and the
// default number of update clients served each frame.
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int N_CLIENTS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// VGA 640x480 timing constants shared by the timing generator and any block
// that monitors the timing stream.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int VCOUNT_W = $clog2(V_TOTAL);

endpackage

// File: rtl/vga_if.sv
// ---------------------------------------------------------------------------
// vga_if
// VGA timing stream bundle.
//   vcount : current line number
//   vblnk  : high during vertical blanking
// Modports: out (timing generator side), in (monitoring side).
// ---------------------------------------------------------------------------
interface vga_if;
  import vga_pkg::*;

  logic [VCOUNT_W-1:0] vcount;
  logic                vblnk;

  modport out (output vcount, output vblnk);
  modport in  (input  vcount, input  vblnk);

endinterface

// File: rtl/vblank_edge_det.sv
// ---------------------------------------------------------------------------
// vblank_edge_det
// Registers a level and flags the cycle in which it is high while its
// registered copy is still low.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset (registered copy cleared to 0)
//   level_i : level to watch
//   rise_o  : high while level_i=1 and the registered copy=0
// ---------------------------------------------------------------------------
module vblank_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/frame_sched.sv
// ---------------------------------------------------------------------------
// frame_sched
// At the start of each vertical blank, serially hands an update slot to each
// game-logic client (request/acknowledge), with a per-client timeout.
// Ports:
//   clk         : pixel clock
//   rst_n       : asynchronous active-low reset
//   vga_in      : VGA timing stream (vblnk watched)
//   upd_req     : per-client update request, one-hot or zero
//   upd_ack     : per-client update-complete acknowledge
//   frame_tick  : one-cycle pulse when a frame update starts
//   busy        : high while clients are being sequenced (REQ and DONE)
//   overrun     : sticky, vblnk fell while a sequence was still running
//   timeout_err : sticky per-client timeout flags
//   frame_cnt   : number of started frame updates, wraps
// ---------------------------------------------------------------------------
module frame_sched
  import game_pkg::*;
#(
  parameter int N_CLIENTS = N_CLIENTS_DEF,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_if.in                    vga_in,
  output logic [N_CLIENTS-1:0] upd_req,
  input  logic [N_CLIENTS-1:0] upd_ack,
  output logic                 frame_tick,
  output logic                 busy,
  output logic                 overrun,
  output logic [N_CLIENTS-1:0] timeout_err,
  output logic [15:0]          frame_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 overrun_q, overrun_d;
  logic [N_CLIENTS-1:0] tmo_err_q, tmo_err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 armed_q, armed_d;

  logic vblnk_rise;
  logic vblnk_fall;
  logic start;
  logic ack_hit;
  logic tmo_hit;

  vblank_edge_det u_rise_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (vga_in.vblnk),
    .rise_o  (vblnk_rise)
  );

  // Falling edge of vblnk is the rising edge of its inverse. Right after
  // reset this can fire once if vblnk is low, but busy is 0 then so it is
  // harmless.
  vblank_edge_det u_fall_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (~vga_in.vblnk),
    .rise_o  (vblnk_fall)
  );

  // The edge register clears to 0 on reset, so vblnk held high across reset
  // release would look like a rise. Starts are only honoured once vblnk has
  // been seen low.
  assign start = vblnk_rise & armed_q;

  always_comb begin
    upd_req = '0;
    if (state_q == REQ) begin
      upd_req[idx_q] = 1'b1;
    end
  end

  // Only the bit of the currently requested client can complete it.
  assign ack_hit = |(upd_ack & upd_req);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_cnt_d    = tmo_cnt_q;
    frame_tick_d = 1'b0;
    overrun_d    = overrun_q;
    tmo_err_d    = tmo_err_q;
    frame_cnt_d  = frame_cnt_q;
    armed_d      = armed_q | ~vga_in.vblnk;

    if (vblnk_fall && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = REQ;
          idx_d        = '0;
          tmo_cnt_d    = '0;
          frame_tick_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      REQ: begin
        if (ack_hit || tmo_hit) begin
          // Ack wins over a simultaneous timeout.
          if (!ack_hit) begin
            tmo_err_d[idx_q] = 1'b1;
          end
          tmo_cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tmo_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
      overrun_q    <= 1'b0;
      tmo_err_q    <= '0;
      frame_cnt_q  <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_cnt_q    <= tmo_cnt_d;
      frame_tick_q <= frame_tick_d;
      overrun_q    <= overrun_d;
      tmo_err_q    <= tmo_err_d;
      frame_cnt_q  <= frame_cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = tmo_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_frame_sched
// Directed scenarios for frame_sched with N_CLIENTS=4, TIMEOUT=8. Stimulus
// pushes the expected tick counts, request segments (client, length) and
// busy lengths into queues; a monitor on the falling clock edge pops and
// compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_frame_sched;
  import vga_pkg::*;

  localparam int NC  = 4;
  localparam int TMO = 8;

  typedef struct {
    int client;
    int len;
  } seg_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] upd_req;
  logic [NC-1:0] upd_ack;
  logic          frame_tick;
  logic          busy;
  logic          overrun;
  logic [NC-1:0] timeout_err;
  logic [15:0]   frame_cnt;

  vga_if vga ();

  int checks   = 0;
  int failures = 0;

  int            ackDelay [NC];
  int            reqAge   [NC];
  logic [NC-1:0] ackReg    = '0;
  logic [NC-1:0] strayMask = '0;
  logic          tieAck    = 1'b0;

  int   expTick [$];
  seg_t expSeg  [$];
  int   expBusy [$];

  logic          segOpen = 1'b0;
  logic [NC-1:0] curReq  = '0;
  int            curLen  = 0;
  int            busyLen = 0;

  // Stray acks on clients that are not being requested are mixed in through
  // strayMask; in tie mode each client acks in the very cycle it is asked.
  assign upd_ack = tieAck ? upd_req : (ackReg | (strayMask & ~upd_req));

  frame_sched #(
    .N_CLIENTS (NC),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_in      (vga),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic reportFail(input string name, input int act);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%0d required=<none>", name, act);
  endtask

  function automatic int idxOf(input logic [NC-1:0] v);
    int r;
    r = -1;
    if ($onehot(v)) begin
      for (int i = 0; i < NC; i++) begin
        if (v[i]) r = i;
      end
    end
    return r;
  endfunction

  task automatic closeSeg();
    seg_t e;
    if (expSeg.size() == 0) begin
      reportFail("req_segment_unexpected", idxOf(curReq));
    end else begin
      e = expSeg.pop_front();
      checkOutput("req_segment_client", idxOf(curReq), e.client);
      checkOutput("req_segment_len", curLen, e.len);
    end
  endtask

  // Client model: each client raises its ack once its request has been high
  // for ackDelay+1 cycles (delay 0 acks in the first request cycle, -1 never).
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NC; i++) begin
      if (upd_req[i]) reqAge[i] = reqAge[i] + 1;
      else reqAge[i] = 0;
      ackReg[i] = upd_req[i] && (ackDelay[i] >= 0) && (reqAge[i] == ackDelay[i] + 1);
    end
  end

  // Monitor: on each falling edge, compare frame ticks against the expected
  // count, and measure request and busy runs; a run is compared when it ends.
  // Reset throws away any run in progress.
  always @(negedge clk) begin
    if (!rst_n) begin
      segOpen = 1'b0;
      curLen  = 0;
      busyLen = 0;
    end else begin
      if (frame_tick) begin
        if (expTick.size() == 0) reportFail("frame_tick_unexpected", frame_cnt);
        else checkOutput("tick_frame_cnt", frame_cnt, expTick.pop_front());
      end
      if (segOpen && (upd_req != curReq)) begin
        closeSeg();
        segOpen = 1'b0;
      end
      if (upd_req != '0) begin
        if (!segOpen) begin
          segOpen = 1'b1;
          curReq  = upd_req;
          curLen  = 1;
        end else begin
          curLen++;
        end
      end
      if (busy) begin
        busyLen++;
      end else if (busyLen > 0) begin
        if (expBusy.size() == 0) reportFail("busy_run_unexpected", busyLen);
        else checkOutput("busy_len", busyLen, expBusy.pop_front());
        busyLen = 0;
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int d0, input int d1, input int d2, input int d3);
    ackDelay[0] = d0;
    ackDelay[1] = d1;
    ackDelay[2] = d2;
    ackDelay[3] = d3;
  endtask

  task automatic pushSeg(input int client, input int len);
    seg_t s;
    s.client = client;
    s.len    = len;
    expSeg.push_back(s);
  endtask

  task automatic pushFourSegs(input int l0, input int l1, input int l2, input int l3);
    pushSeg(0, l0);
    pushSeg(1, l1);
    pushSeg(2, l2);
    pushSeg(3, l3);
  endtask

  task automatic startFrame();
    checkOutput("tick_before_edge", frame_tick, 0);
    vga.vcount = VCOUNT_W'(V_ACTIVE);
    vga.vblnk  = 1'b1;
    stepCycles(1);
    checkOutput("tick_latency", frame_tick, 1);
    checkOutput("busy_set", busy, 1);
    checkOutput("req0_first", upd_req, 4'b0001);
  endtask

  task automatic endFrame();
    vga.vblnk  = 1'b0;
    vga.vcount = '0;
    stepCycles(3);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      stepCycles(1);
      n++;
    end
    if (busy) reportFail("idle_budget_expired", n);
  endtask

  // Directed scenarios run in sequence, expectations pushed before each frame.
  initial begin
    rst_n      = 1'b1;
    vga.vblnk  = 1'b0;
    vga.vcount = '0;
    applyStimulus(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_upd_req", upd_req, 0);
    checkOutput("reset_frame_tick", frame_tick, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    checkOutput("reset_frame_cnt", frame_cnt, 0);
    stepCycles(2);
    rst_n = 1'b1;
    stepCycles(2);

    $display("[TB] normal frame, acks after 3 cycles, stray acks on idle clients");
    applyStimulus(3, 3, 3, 3);
    strayMask = 4'b1111;
    expTick.push_back(1);
    pushFourSegs(4, 4, 4, 4);
    expBusy.push_back(17);
    startFrame();
    waitIdle(60);
    checkOutput("normal_frame_cnt", frame_cnt, 1);
    checkOutput("normal_timeout_err", timeout_err, 0);
    checkOutput("normal_overrun", overrun, 0);
    strayMask = '0;
    endFrame();

    $display("[TB] immediate ack, ack tied to req");
    tieAck = 1'b1;
    expTick.push_back(2);
    pushFourSegs(1, 1, 1, 1);
    expBusy.push_back(5);
    startFrame();
    stepCycles(4);
    checkOutput("done_cycle_req", upd_req, 0);
    checkOutput("done_cycle_busy", busy, 1);
    stepCycles(1);
    checkOutput("idle_after_done", busy, 0);
    tieAck = 1'b0;
    endFrame();

    $display("[TB] timeout on client 2, ack and expiry together on client 0");
    applyStimulus(7, 2, -1, 0);
    expTick.push_back(3);
    pushFourSegs(8, 3, 8, 1);
    expBusy.push_back(21);
    startFrame();
    waitIdle(60);
    checkOutput("timeout_err_bits", timeout_err, 4'b0100);
    checkOutput("timeout_frame_cnt", frame_cnt, 3);
    endFrame();

    $display("[TB] overrun, vblnk falls and rises again while client 1 works");
    applyStimulus(0, 6, 0, 0);
    expTick.push_back(4);
    pushFourSegs(1, 7, 1, 1);
    expBusy.push_back(11);
    startFrame();
    checkOutput("overrun_before_fall", overrun, 0);
    stepCycles(2);
    vga.vblnk = 1'b0;
    stepCycles(2);
    vga.vblnk = 1'b1;
    stepCycles(2);
    checkOutput("overrun_req1_still_high", upd_req, 4'b0010);
    waitIdle(60);
    checkOutput("overrun_flag", overrun, 1);
    checkOutput("overrun_frame_cnt", frame_cnt, 4);
    checkOutput("overrun_timeout_err_kept", timeout_err, 4'b0100);
    endFrame();

    $display("[TB] reset while client 1 is requested");
    applyStimulus(0, -1, 0, 0);
    expTick.push_back(5);
    pushSeg(0, 1);
    startFrame();
    stepCycles(2);
    checkOutput("mid_req1_high", upd_req, 4'b0010);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_upd_req", upd_req, 0);
    checkOutput("midrst_frame_tick", frame_tick, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_overrun", overrun, 0);
    checkOutput("midrst_timeout_err", timeout_err, 0);
    checkOutput("midrst_frame_cnt", frame_cnt, 0);
    stepCycles(2);
    rst_n = 1'b1;
    stepCycles(4);
    checkOutput("no_start_without_edge_busy", busy, 0);
    checkOutput("no_start_without_edge_cnt", frame_cnt, 0);
    applyStimulus(0, 0, 0, 0);
    vga.vblnk = 1'b0;
    stepCycles(2);
    expTick.push_back(1);
    pushFourSegs(1, 1, 1, 1);
    expBusy.push_back(5);
    startFrame();
    waitIdle(60);
    checkOutput("restart_frame_cnt", frame_cnt, 1);
    endFrame();

    $display("[TB] frame counter wrap");
    force dut.frame_cnt_q = 16'hFFFF;
    stepCycles(1);
    release dut.frame_cnt_q;
    stepCycles(1);
    checkOutput("preload_frame_cnt", frame_cnt, 16'hFFFF);
    expTick.push_back(0);
    pushFourSegs(1, 1, 1, 1);
    expBusy.push_back(5);
    startFrame();
    waitIdle(60);
    checkOutput("wrap_frame_cnt", frame_cnt, 0);
    endFrame();

    stepCycles(2);
    checkOutput("tick_queue_drained", expTick.size(), 0);
    checkOutput("segment_queue_drained", expSeg.size(), 0);
    checkOutput("busy_queue_drained", expBusy.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
